// File: rtl/key_event.sv
// Key event decoder: turns a debounced key level into press, release, short,
// long and auto-repeat pulses. Auto-repeat is built only with KEY_REPEAT_EN.
module key_event #(
    parameter logic ACTIVE_LVL  = 1'b0,
    parameter int   LONG_TIME   = 24000000,
    parameter int   REPEAT_TIME = 4800000,
    parameter int   BITS        = 25
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_i,
    output logic press_o,
    output logic release_o,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    // state | meaning
    // IDLE  | key released, waiting for a press
    // HELD  | key pressed, counting toward a long press
    // LONG  | long press reached, counting repeat intervals
    typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

    localparam logic [BITS-1:0] LONG_LAST = BITS'(LONG_TIME - 1);
    localparam int HOLD_MAX = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;

    // Counter must reach HOLD_MAX-1 without wrapping.
    if (longint'(HOLD_MAX) > (longint'(1) << BITS)) begin : g_bits_too_small
        $error("key_event: BITS too small for LONG_TIME/REPEAT_TIME");
    end

    state_t          state_q;
    logic [BITS-1:0] cnt_q;
    logic            key_d_q;
    logic            press_q;
    logic            release_q;
    logic            short_q;
    logic            long_q;
    logic            held_q;
    logic            press;
    logic            release_ev;

    assign press      = (key_i == ACTIVE_LVL) && (key_d_q != ACTIVE_LVL);
    assign release_ev = (key_i != ACTIVE_LVL) && (key_d_q == ACTIVE_LVL);

`ifdef KEY_REPEAT_EN
    localparam logic [BITS-1:0] REPEAT_LAST = BITS'(REPEAT_TIME - 1);
    logic repeat_q;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            key_d_q   <= ~ACTIVE_LVL;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            key_d_q   <= key_i;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (press) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                HELD: begin
                    // Release wins over a coincident long-press terminal count.
                    if (release_ev) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= LONG;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + BITS'(1);
                    end
                end
                LONG: begin
                    if (release_ev) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_q    <= '0;
                        repeat_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + BITS'(1);
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign press_o   = press_q;
    assign release_o = release_q;
    assign short_o   = short_q;
    assign long_o    = long_q;
    assign held_o    = held_q;
`ifdef KEY_REPEAT_EN
    assign repeat_o  = repeat_q;
`else
    assign repeat_o  = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with ACTIVE_LVL=0, LONG_TIME=10, REPEAT_TIME=4.
// Observed vector order: {press, release, short, long, repeat, held}.
module tb_key_event;

`ifdef KEY_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    logic key_i;
    logic press_o, release_o, short_o, long_o, repeat_o, held_o;

    int vectors = 0;
    int miscompares = 0;

    key_event #(
        .ACTIVE_LVL (1'b0),
        .LONG_TIME  (10),
        .REPEAT_TIME(4),
        .BITS       (4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .key_i    (key_i),
        .press_o  (press_o),
        .release_o(release_o),
        .short_o  (short_o),
        .long_o   (long_o),
        .repeat_o (repeat_o),
        .held_o   (held_o)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [5:0] outs();
        return {press_o, release_o, short_o, long_o, repeat_o, held_o};
    endfunction

    task automatic check(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = outs();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive key level, let one rising edge sample it, then check the outputs.
    task automatic cyc(input logic k, input logic [5:0] exp, input string tag);
        key_i = k;
        @(posedge sys_clk);
        #1;
        check(tag, exp);
    endtask

    task automatic long_hold(input int n, input string tag);
        logic [5:0] exp;
        cyc(1'b0, 6'b100001, {tag, "_press"});
        for (int i = 1; i < n; i++) begin
            exp = 6'b000001;
            if (i == 10) exp = 6'b000101;
            else if (RPT && i > 10 && ((i - 10) % 4) == 0) exp = 6'b000011;
            cyc(1'b0, exp, $sformatf("%s_hold%0d", tag, i));
        end
        cyc(1'b1, 6'b010000, {tag, "_release"});
        cyc(1'b1, 6'b000000, {tag, "_idle"});
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_i     = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset", 6'b000000);
        sys_rst_n = 1'b1;
        cyc(1'b1, 6'b000000, "post_reset_idle");

        // Short press: 5 low cycles.
        cyc(1'b0, 6'b100001, "short_press");
        for (int i = 1; i < 5; i++) cyc(1'b0, 6'b000001, "short_hold");
        cyc(1'b1, 6'b011000, "short_release");
        cyc(1'b1, 6'b000000, "short_idle");

        // Release sampled exactly when count==9: short wins over long.
        cyc(1'b0, 6'b100001, "edge_press");
        for (int i = 1; i < 10; i++) cyc(1'b0, 6'b000001, "edge_hold");
        cyc(1'b1, 6'b011000, "edge_release");
        cyc(1'b1, 6'b000000, "edge_idle");

        // Long holds: 20 cycles, then 30 cycles (release coincides with a repeat count).
        long_hold(20, "long20");
        long_hold(30, "long30");

        // Reset in the middle of a 7-cycle hold, key kept low.
        cyc(1'b0, 6'b100001, "rst_press");
        for (int i = 1; i < 7; i++) cyc(1'b0, 6'b000001, "rst_hold");
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("rst_immediate", 6'b000000);
        cyc(1'b0, 6'b000000, "rst_held_low");
        sys_rst_n = 1'b1;
        cyc(1'b0, 6'b100001, "rst_repress");
        cyc(1'b0, 6'b000001, "rst_rehold");
        cyc(1'b1, 6'b011000, "rst_release");
        cyc(1'b1, 6'b000000, "rst_idle");

        // Key toggling every 2 cycles for 20 cycles.
        for (int p = 0; p < 5; p++) begin
            cyc(1'b0, 6'b100001, "tog_press");
            cyc(1'b0, 6'b000001, "tog_held");
            cyc(1'b1, 6'b011000, "tog_release");
            cyc(1'b1, 6'b000000, "tog_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
